lamp_switch_sequencer: RTL and testbench

//   Drives the three staircase switch inputs (S3,S2,S1) of the lamp controller through
//   all 8 combinations 000..111, holding each for HOLD_CYCLES clocks, and reads back the

---
 rtl/lamp_switch_sequencer.sv | 117 +++++++++++
 tb/tb_lamp_switch_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lamp_switch_sequencer.sv
// Self-test sequencer: steps {S3,S2,S1} through 000..111, holds each HOLD_CYCLES clocks and checks F == ^vector.
// busy rises one edge after start; a single pass occupies 8*HOLD_CYCLES cycles and is followed by a one-cycle done pulse.
module lamp_switch_sequencer #(
    parameter int unsigned HOLD_CYCLES = 50,
    parameter int unsigned ERR_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             loop_en,
    input  logic             F,
    output logic             S3,
    output logic             S2,
    output logic             S1,
    output logic             busy,
    output logic             done,
    output logic [ERR_W-1:0] err_cnt,
    output logic [2:0]       first_fail
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [15:0]      LAST    = 16'(HOLD_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    state_t           state_q;
    logic [15:0]      cnt_q;
    logic [2:0]       vec_q;
    logic [2:0]       sw_q;
    logic             loop_q;
    logic             busy_q;
    logic             done_q;
    logic [ERR_W-1:0] err_q;
    logic [2:0]       ff_q;

    logic settled_d;
    logic mismatch_d;

    // F is only trusted on the last cycle of a hold, after the lamp path has settled.
    assign settled_d  = (cnt_q == LAST);
    assign mismatch_d = F ^ (^vec_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            sw_q    <= '0;
            loop_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
            ff_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    sw_q   <= '0;
                    busy_q <= 1'b0;
                    if (start && !abort) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        err_q   <= '0;
                        ff_q    <= '0;
                        vec_q   <= '0;
                        cnt_q   <= '0;
                        loop_q  <= loop_en;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        sw_q    <= '0;
                    end else if (settled_d) begin
                        if (mismatch_d) begin
                            if (err_q != ERR_MAX) err_q <= err_q + 1'b1;
                            if (err_q == '0)      ff_q  <= vec_q;
                        end
                        cnt_q <= '0;
                        vec_q <= vec_q + 3'd1;
                        if (vec_q == 3'd7 && !loop_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            sw_q    <= '0;
                        end else begin
                            sw_q <= vec_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    sw_q    <= '0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    sw_q    <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign S3         = sw_q[2];
    assign S2         = sw_q[1];
    assign S1         = sw_q[0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign err_cnt    = err_q;
    assign first_fail = ff_q;

endmodule

// File: tb/tb_lamp_switch_sequencer.sv
// Directed bench: table of single-pass runs plus hand-written abort, loop, reset and short-hold sequences.
module tb_lamp_switch_sequencer;

    localparam int H1 = 50;
    localparam int H2 = 2;

    localparam logic [1:0] M_GOOD = 2'd0;
    localparam logic [1:0] M_ST0  = 2'd1;
    localparam logic [1:0] M_ST1  = 2'd2;
    localparam logic [1:0] M_INV  = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       start2 = 1'b0;
    logic       abort = 1'b0;
    logic       loop_en = 1'b0;
    logic       F, F2;
    logic       S3, S2, S1, busy, done;
    logic       T3, T2, T1, busy2, done2;
    logic [3:0] err_cnt, err_cnt2;
    logic [2:0] first_fail, first_fail2;
    logic [1:0] fmode = 2'd0;
    logic [2:0] sw, sw2;

    // Expected lamp value per vector 000..111: 0 1 1 0 1 0 0 1
    logic [7:0] lut = 8'b1001_0110;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign sw  = {S3, S2, S1};
    assign sw2 = {T3, T2, T1};

    always_comb begin
        F = 1'b0;
        case (fmode)
            M_GOOD:  F = lut[sw];
            M_ST0:   F = 1'b0;
            M_ST1:   F = 1'b1;
            default: F = ~lut[sw];
        endcase
    end
    assign F2 = lut[sw2];

    lamp_switch_sequencer #(.HOLD_CYCLES(H1), .ERR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .loop_en(loop_en), .F(F),
        .S3(S3), .S2(S2), .S1(S1), .busy(busy), .done(done),
        .err_cnt(err_cnt), .first_fail(first_fail)
    );

    lamp_switch_sequencer #(.HOLD_CYCLES(H2), .ERR_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort), .loop_en(loop_en), .F(F2),
        .S3(T3), .S2(T2), .S1(T1), .busy(busy2), .done(done2),
        .err_cnt(err_cnt2), .first_fail(first_fail2)
    );

    typedef struct {
        logic [1:0] fm;
        int         exp_err;
        logic [2:0] exp_ff;
        int         restart_at;
    } run_t;

    run_t runs[6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_pass(input logic [1:0] m, input int exp_err, input logic [2:0] exp_ff,
                            input int restart_at);
        fmode = m;
        pulse_start();
        check("start_busy", {31'd0, busy}, 1);
        check("start_err_clear", {28'd0, err_cnt}, 0);
        for (int c = 1; c <= 8 * H1; c++) begin
            start = (c == restart_at);
            if ((c - 1) % H1 == 0 || c % H1 == 0) begin
                check("vec_hold", {29'd0, sw}, (c - 1) / H1);
                check("busy_run", {31'd0, busy}, 1);
                check("no_early_done", {31'd0, done}, 0);
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("done_at_8H+1", {31'd0, done}, 1);
        check("busy_at_done", {31'd0, busy}, 0);
        check("sw_at_done", {29'd0, sw}, 0);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 0);
        check("err_cnt", {28'd0, err_cnt}, exp_err);
        check("first_fail", {29'd0, first_fail}, exp_ff);
    endtask

    initial begin
        int done_seen;
        int done_c;

        runs[0] = '{M_GOOD, 0, 3'b000, 0};
        runs[1] = '{M_ST0,  4, 3'b001, 0};
        runs[2] = '{M_ST1,  4, 3'b000, 0};
        runs[3] = '{M_INV,  8, 3'b000, 0};
        runs[4] = '{M_ST0,  4, 3'b001, 2 * H1};
        runs[5] = '{M_GOOD, 0, 3'b000, 0};

        repeat (3) @(negedge clk);
        check("rst_sw", {29'd0, sw}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_err", {28'd0, err_cnt}, 0);
        check("rst_ff", {29'd0, first_fail}, 0);
        check("rst_busy2", {31'd0, busy2}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_pass(runs[i].fm, runs[i].exp_err, runs[i].exp_ff, runs[i].restart_at);

        // Looping with inverted F: 24 mismatches saturate the counter, no done ever.
        fmode = M_INV;
        loop_en = 1'b1;
        pulse_start();
        loop_en = 1'b0;
        done_seen = 0;
        for (int c = 1; c <= 24 * H1; c++) begin
            if (done) done_seen++;
            if (c == 8 * H1 + 1) begin
                check("loop_wrap_vec", {29'd0, sw}, 0);
                check("loop_wrap_busy", {31'd0, busy}, 1);
            end
            @(negedge clk);
        end
        check("loop_no_done", done_seen, 0);
        check("loop_err_sat", {28'd0, err_cnt}, 15);
        check("loop_ff", {29'd0, first_fail}, 0);
        check("loop_busy", {31'd0, busy}, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_sw", {29'd0, sw}, 0);
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_done", {31'd0, done}, 0);
        check("abort_err_kept", {28'd0, err_cnt}, 15);

        // Abort on the settled cycle of vector 0 must discard that compare.
        fmode = M_INV;
        pulse_start();
        for (int c = 1; c < H1; c++) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_discard_err", {28'd0, err_cnt}, 0);
        check("abort_discard_busy", {31'd0, busy}, 0);
        done_seen = 0;
        repeat (5) begin
            if (done) done_seen++;
            @(negedge clk);
        end
        check("abort_no_done", done_seen, 0);

        // abort and start together while idle: stay idle.
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check("abort_wins_busy", {31'd0, busy}, 0);
        @(negedge clk);
        check("abort_wins_busy2", {31'd0, busy}, 0);

        // Asynchronous reset in the middle of vector 5.
        fmode = M_GOOD;
        pulse_start();
        for (int c = 1; c < 5 * H1 + 25; c++) @(negedge clk);
        check("pre_rst_vec", {29'd0, sw}, 5);
        rst_n = 1'b0;
        #1;
        check("async_rst_sw", {29'd0, sw}, 0);
        check("async_rst_busy", {31'd0, busy}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (4 * H1) begin
            if (done) done_seen++;
            @(negedge clk);
        end
        check("rst_no_done", done_seen, 0);
        check("rst_stays_idle", {31'd0, busy}, 0);

        // Short hold: full pass in 16 cycles, done on cycle 17.
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        done_c = -1;
        for (int c = 1; c <= 40; c++) begin
            if (done2) begin
                done_c = c;
                break;
            end
            if (c <= 16) check("h2_vec", {29'd0, sw2}, (c - 1) / H2);
            @(negedge clk);
        end
        check("h2_done_cycle", done_c, 17);
        check("h2_err", {28'd0, err_cnt2}, 0);
        @(negedge clk);
        check("h2_busy_after", {31'd0, busy2}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
